// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter slice: op codes, default width,
// and the output-stage state encoding.
package logic_unit_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_ANDN = 2'b11;

   // The FULL encoding doubles as the result-valid flag.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise logic unit: res = op(a, b).
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] arg0,
   input  logic [WIDTH-1:0] arg2,
   output logic [WIDTH-1:0] res
);

   always_comb begin
      res = '0;
      case (op)
         OP_AND:  res = arg0 & arg2;
         OP_OR:   res = arg0 | arg2;
         OP_XOR:  res = arg0 ^ arg2;
         OP_ANDN: res = arg0 & ~arg2;
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter for two requesters sharing one logic unit, with a
// single-entry registered result stage and per-requester grant counters.
module logic_unit_arbiter
   import logic_unit_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock_5,
   input  logic             reset_5,
   input  logic             req0_valid_5,
   output logic             req0_ready_5,
   input  logic [1:0]       req0_op_5,
   input  logic [WIDTH-1:0] req0_arg0_5,
   input  logic [WIDTH-1:0] req0_arg2_5,
   input  logic             req1_valid_5,
   output logic             req1_ready_5,
   input  logic [1:0]       req1_op_5,
   input  logic [WIDTH-1:0] req1_arg0_5,
   input  logic [WIDTH-1:0] req1_arg2_5,
   output logic             res_valid_5,
   input  logic             res_ready_5,
   output logic [WIDTH-1:0] res_5,
   output logic             res_id_5,
   output logic [CNT_W-1:0] grants0_5,
   output logic [CNT_W-1:0] grants1_5
);

   out_state_t       r_state;
   out_state_t       w_state_nxt;
   logic             r_last_grant;
   logic [WIDTH-1:0] r_res;
   logic             r_res_id;
   logic [CNT_W-1:0] r_grants0;
   logic [CNT_W-1:0] r_grants1;

   logic             w_slot_free;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_ready0;
   logic             w_ready1;
   logic             w_accept;
   logic             w_sel;
   logic [1:0]       w_op;
   logic [WIDTH-1:0] w_arg0;
   logic [WIDTH-1:0] w_arg2;
   logic [WIDTH-1:0] w_core_res;

   // Slot is free when empty or being drained this cycle.
   assign w_slot_free = (r_state == ST_EMPTY) || res_ready_5;

   // Under contention the requester not granted last wins.
   assign w_grant0 = req0_valid_5 && (!req1_valid_5 || r_last_grant);
   assign w_grant1 = req1_valid_5 && (!req0_valid_5 || !r_last_grant);

   assign w_ready0 = w_grant0 && w_slot_free && !reset_5;
   assign w_ready1 = w_grant1 && w_slot_free && !reset_5;
   assign w_accept = w_ready0 || w_ready1;
   assign w_sel    = w_ready1;

   assign w_op   = w_sel ? req1_op_5   : req0_op_5;
   assign w_arg0 = w_sel ? req1_arg0_5 : req0_arg0_5;
   assign w_arg2 = w_sel ? req1_arg2_5 : req0_arg2_5;

   logic_unit_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op   (w_op),
      .arg0 (w_arg0),
      .arg2 (w_arg2),
      .res  (w_core_res)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept)                 w_state_nxt = ST_FULL;
         ST_FULL:  if (res_ready_5 && !w_accept) w_state_nxt = ST_EMPTY;
         default:                                w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clock_5) begin
      if (reset_5) begin
         r_state      <= ST_EMPTY;
         r_last_grant <= 1'b1;
         r_res        <= '0;
         r_res_id     <= 1'b0;
         r_grants0    <= '0;
         r_grants1    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_last_grant <= w_sel;
            r_res        <= w_core_res;
            r_res_id     <= w_sel;
         end
         if (w_ready0) r_grants0 <= r_grants0 + CNT_W'(1);
         if (w_ready1) r_grants1 <= r_grants1 + CNT_W'(1);
      end
   end

   assign req0_ready_5 = w_ready0;
   assign req1_ready_5 = w_ready1;
   assign res_valid_5  = (r_state == ST_FULL);
   assign res_5        = r_res;
   assign res_id_5     = r_res_id;
   assign grants0_5    = r_grants0;
   assign grants1_5    = r_grants1;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_logic_unit_arbiter;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             v0, v1, rr;
   logic             r0, r1;
   logic [1:0]       op0, op1;
   logic [WIDTH-1:0] a0, b0, a1, b1;
   logic             res_valid;
   logic [WIDTH-1:0] res;
   logic             res_id;
   logic [CNT_W-1:0] g0, g1;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: what the output stage should be holding.
   bit          m_valid;
   logic [31:0] m_res;
   bit          m_id;
   int          m_cnt0, m_cnt1;
   int          m_last;
   bit          acc0, acc1;
   logic        d_r0, d_r1;

   always #5 clk = ~clk;

   logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock_5      (clk),
      .reset_5      (rst),
      .req0_valid_5 (v0),
      .req0_ready_5 (r0),
      .req0_op_5    (op0),
      .req0_arg0_5  (a0),
      .req0_arg2_5  (b0),
      .req1_valid_5 (v1),
      .req1_ready_5 (r1),
      .req1_op_5    (op1),
      .req1_arg0_5  (a1),
      .req1_arg2_5  (b1),
      .res_valid_5  (res_valid),
      .res_ready_5  (rr),
      .res_5        (res),
      .res_id_5     (res_id),
      .grants0_5    (g0),
      .grants1_5    (g1)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] ref_op(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      logic [31:0] r;
      case (op)
         2'd0:    r = a & b;
         2'd1:    r = a | b;
         2'd2:    r = a ^ b;
         default: r = a & ~b;
      endcase
      return r;
   endfunction

   // One clock: check everything at the falling edge, then advance the model.
   task automatic step();
      bit slot;
      int win;
      bit e0, e1;
      @(negedge clk);
      slot = !m_valid || rr;
      if (v0 && v1)  win = 1 - m_last;
      else if (v1)   win = 1;
      else           win = 0;
      e0 = !rst && slot && v0 && (win == 0);
      e1 = !rst && slot && v1 && (win == 1);
      d_r0 = r0;
      d_r1 = r1;
      chk("req0_ready", 32'(r0), 32'(e0));
      chk("req1_ready", 32'(r1), 32'(e1));
      chk("res_valid",  32'(res_valid), 32'(m_valid));
      chk("res",        res, m_res);
      chk("res_id",     32'(res_id), 32'(m_id));
      chk("grants0",    32'(g0), 32'(m_cnt0 % 65536));
      chk("grants1",    32'(g1), 32'(m_cnt1 % 65536));
      acc0 = e0;
      acc1 = e1;
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_res = '0; m_id = 0; m_cnt0 = 0; m_cnt1 = 0; m_last = 1;
      end else if (e0 || e1) begin
         m_valid = 1;
         m_id    = e1;
         m_res   = e1 ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
         m_last  = e1 ? 1 : 0;
         if (e0) m_cnt0++;
         if (e1) m_cnt1++;
      end else if (rr) begin
         m_valid = 0;
      end
      #1;
   endtask

   typedef struct {
      bit          id;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{1'b0, 2'b00, 32'h9C36, 32'hE51A, 32'h00008412};
      vecs[1] = '{1'b1, 2'b01, 32'h9C36, 32'hE51A, 32'h0000FD3E};
      vecs[2] = '{1'b1, 2'b10, 32'h9C36, 32'hE51A, 32'h0000792C};
      vecs[3] = '{1'b1, 2'b11, 32'h9C36, 32'hE51A, 32'h00001824};

      rst = 1; v0 = 0; v1 = 0; rr = 1;
      op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      m_valid = 0; m_res = '0; m_id = 0; m_cnt0 = 0; m_cnt1 = 0; m_last = 1;
      #1;
      step(); step();
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_res",   res, 32'd0);
      chk("rst_g0",    32'(g0), 32'd0);
      rst = 0;

      // Vector table: single-requester ops, result one cycle after accept.
      for (int i = 0; i < 4; i++) begin
         if (vecs[i].id) begin v1 = 1; op1 = vecs[i].op; a1 = vecs[i].a; b1 = vecs[i].b; end
         else            begin v0 = 1; op0 = vecs[i].op; a0 = vecs[i].a; b0 = vecs[i].b; end
         step();
         v0 = 0; v1 = 0;
         chk("vec_valid", 32'(res_valid), 32'd1);
         chk("vec_res",   res, vecs[i].exp_res);
         chk("vec_id",    32'(res_id), 32'(vecs[i].id));
      end
      chk("vec_g0", 32'(g0), 32'd1);
      chk("vec_g1", 32'(g1), 32'd3);
      step();

      // Contention from reset: strict alternation starting with req0.
      rst = 1; step(); rst = 0;
      v0 = 1; v1 = 1; op0 = 2'b00; op1 = 2'b10; rr = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("alt_r0", 32'(d_r0), 32'((i % 2) == 0));
         chk("alt_r1", 32'(d_r1), 32'((i % 2) == 1));
      end
      v0 = 0; v1 = 0;
      chk("alt_g0", 32'(g0), 32'd4);
      chk("alt_g1", 32'(g1), 32'd4);

      // Stall with a pending req1, then release.
      step();
      rr = 0; v0 = 1; op0 = 2'b00; a0 = 32'h9C36; b0 = 32'hE51A;
      step();
      v0 = 0; v1 = 1; op1 = 2'b10; a1 = 32'h9C36; b1 = 32'hE51A;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_r1",  32'(d_r1), 32'd0);
         chk("stall_r0",  32'(d_r0), 32'd0);
         chk("stall_res", res, 32'h00008412);
      end
      rr = 1;
      step();
      chk("release_r1", 32'(d_r1), 32'd1);
      v1 = 0;
      chk("release_res", res, 32'h0000792C);
      chk("release_id",  32'(res_id), 32'd1);

      // Reset while FULL with both requesters valid.
      rr = 0; v0 = 1; step();
      v1 = 1; rst = 1;
      step();
      chk("rstfull_r0",    32'(d_r0), 32'd0);
      chk("rstfull_r1",    32'(d_r1), 32'd0);
      chk("rstfull_valid", 32'(res_valid), 32'd0);
      chk("rstfull_g0",    32'(g0), 32'd0);
      chk("rstfull_g1",    32'(g1), 32'd0);
      rst = 0; rr = 1;
      step();
      chk("postrst_r0", 32'(d_r0), 32'd1);
      chk("postrst_r1", 32'(d_r1), 32'd0);
      v0 = 0; v1 = 0;
      step();

      // Randomized traffic; a requester holds its payload until accepted.
      for (int i = 0; i < 3000; i++) begin
         if (!(v0 && !acc0)) begin
            v0 = 1'($urandom_range(0, 1)); op0 = 2'($urandom); a0 = $urandom; b0 = $urandom;
         end
         if (!(v1 && !acc1)) begin
            v1 = 1'($urandom_range(0, 1)); op1 = 2'($urandom); a1 = $urandom; b1 = $urandom;
         end
         rr  = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 199) == 0);
         if (rst) begin acc0 = 0; acc1 = 0; end
         step();
         if (rst) begin v0 = 0; v1 = 0; end
      end

      // Counter wrap on requester 0.
      rst = 1; v0 = 0; v1 = 0; rr = 1; step(); rst = 0;
      v0 = 1; op0 = 2'b01;
      repeat (65535) @(posedge clk);
      #1;
      chk("wrap_max", 32'(g0), 32'h0000FFFF);
      @(posedge clk); #1;
      chk("wrap_zero", 32'(g0), 32'h00000000);
      v0 = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Two-requester arbiter and sequencer for the shared 32-bit bitwise logic datapath (arg0/arg2 → res). It accepts operation requests from two independent valid/ready channels and grants them round-robin. Each granted request is issued to one combinational logic unit. The result is registered into a single-entry output stage with its own valid/ready handshake. Sits between the dataflow producers and the shared logic unit, so the unit is instantiated once rather than per consumer.

## Interface
- WIDTH, 32, operand/result width
- CNT_W, 16, width of per-requester grant counters

- clock_5  in  1  clock, all state on rising edge
- reset_5  in  1  synchronous, active-high reset
- req0_valid_5  in  1  requester 0 has a request
- req0_ready_5  out  1  requester 0 request accepted this cycle
- req0_op_5  in  2  op code, requester 0
- req0_arg0_5 / req0_arg2_5  in  WIDTH  operands, requester 0
- req1_valid_5, req1_ready_5, req1_op_5, req1_arg0_5, req1_arg2_5: same for requester 1
- res_valid_5  out  1  output register holds a result
- res_ready_5  in  1  consumer takes result
- res_5  out  WIDTH  result
- res_id_5  out  1  requester index that produced res_5
- grants0_5 / grants1_5  out  CNT_W  accepted-request counters, wrap modulo 2^CNT_W

## Operation
- Op codes: 00 AND (a&b), 01 OR, 10 XOR, 11 ANDN (a&~b); a=argN_arg0, b=argN_arg2.
- Slot free when `!res_valid_5 || res_ready_5`; no request is accepted when the slot is not free.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - `last_grant` updates only on an actual accept (grant && slot free).
- reqN_ready_5 = grantN && slot free. It is combinational from the valids and res_ready_5, and never asserted toward a requester whose valid is low.
- Handshakes:
  - Accept on valid && ready.
  - Requesters hold op and operands stable while valid and not ready.
  - A requester that is not granted keeps waiting. Round-robin bounds its wait to one grant of the other requester.
- On accept:
  - Operation result is loaded into res_5.
  - res_id_5 is set to the requester index.
  - res_valid_5 is set to 1.
  - grantsN_5 is incremented.
- On res_valid_5 && res_ready_5 with no new accept: res_valid_5 clears. res_5 and res_id_5 hold their last values.
- Drain and accept in the same cycle: the new result replaces the old one, res_valid_5 stays 1, giving back-to-back throughput.
- Output state machine:
  - EMPTY: EMPTY→FULL on accept.
  - FULL: FULL→EMPTY on drain without accept; FULL→FULL on drain with accept or on stall.
  - res_valid_5 is the state bit.
- Reset:
  - res_valid_5=0, res_5=0, res_id_5=0, grants0_5=grants1_5=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Both readies are 0 while reset_5 is high.
  - Reset mid-operation discards the held result and any pending grant.

## Timing
- Latency: accept in cycle t → res_valid_5=1 with the result in cycle t+1.
- Throughput: 1 result/cycle while res_ready_5 is held 1.
- Stall: res_ready_5=0 with FULL holds res_5 and res_id_5 stable and keeps both readies 0.
- Counter wrap: 2^CNT_W−1 + 1 → 0, with no flag.

## Structure
- Package logic_unit_pkg:
  - op code localparams (OP_AND/OP_OR/OP_XOR/OP_ANDN)
  - default WIDTH
- Sub-module logic_unit_core: purely combinational op/arg0/arg2 → res, WIDTH-parameterised, one instance.
- Arbiter, output register and counters live in logic_unit_arbiter.

## Test plan
- After reset, req0 only: op=00, arg0=0x9C36, arg2=0xE51A, res_ready_5=1 → next cycle res_valid_5=1, res_5=0x00008412, res_id_5=0, grants0_5=1.
- Op sweep on req1 with the same operands:
  - OR → 0x0000FD3E
  - XOR → 0x0000792C
  - ANDN → 0x00001824
  - res_id_5=1 each time, grants1_5=3
- Both valid every cycle, res_ready_5=1 → grants alternate 0,1,0,1. After 8 cycles grants0_5=grants1_5=4, and the first grant goes to req0.
- res_ready_5=0 with FULL for 5 cycles → res_5 stable, both readies 0, pending req1 not lost. res_ready_5=1 → req1 accepted the same cycle and its result appears the next cycle.
- reset_5 asserted while FULL with both requesters valid → next cycle res_valid_5=0, counters 0, readies 0 during reset. The first post-reset contention grants req0.
- Preload grants0_5 to 0xFFFF via 65535 accepts, then one more accept → grants0_5=0x0000.
